// File: rtl/ibex_host_arb.sv
// Round-robin arbiter sharing one Ibex host port between N_REQ Ibex-protocol requesters,
// with an in-order owner FIFO that routes each response back to the requester that issued it.
module ibex_host_arb #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*AW-1:0]     addr_i,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [N_REQ*DW/8-1:0]   be_i,
  input  logic [N_REQ*DW-1:0]     wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [N_REQ-1:0]        err_o,
  output logic [DW-1:0]           rdata_o,
  output logic                    host_req_o,
  output logic [AW-1:0]           host_addr_o,
  output logic                    host_we_o,
  output logic [DW/8-1:0]         host_be_o,
  output logic [DW-1:0]           host_wdata_o,
  input  logic                    host_gnt_i,
  input  logic                    host_rvalid_i,
  input  logic                    host_err_i,
  input  logic [DW-1:0]           host_rdata_i,
  output logic                    unexp_rsp_o
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int BW  = DW / 8;

  typedef enum logic {
    ST_FREE,
    ST_LOCKED
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   sel_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             unexp_q;
  logic [IDW-1:0]   fifo_q [MAX_OUT];

  logic [IDW-1:0]   free_win;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   head;
  logic [IDW-1:0]   ptr_next;
  logic [PW-1:0]    wr_next;
  logic [PW-1:0]    rd_next;
  logic             full;
  logic             grant;
  logic             pop;

  // First requesting index at or after ptr_q, wrapping around.
  always_comb begin
    free_win = '0;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        found    = 1'b1;
        free_win = IDW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign win  = (state_q == ST_LOCKED) ? sel_q : free_win;
  assign full = (cnt_q == CW'(MAX_OUT));
  assign head = fifo_q[rd_ptr_q];

  assign host_req_o   = ((state_q == ST_FREE) ? |req_i : 1'b1) & ~full;
  assign host_addr_o  = addr_i[int'(win)*AW +: AW];
  assign host_we_o    = we_i[win];
  assign host_be_o    = be_i[int'(win)*BW +: BW];
  assign host_wdata_o = wdata_i[int'(win)*DW +: DW];

  assign grant = host_gnt_i & host_req_o;
  assign pop   = host_rvalid_i & (cnt_q != '0);

  assign rdata_o     = host_rdata_i;
  assign unexp_rsp_o = unexp_q;

  assign ptr_next = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  assign wr_next  = (int'(wr_ptr_q) == MAX_OUT - 1) ? '0 : wr_ptr_q + 1'b1;
  assign rd_next  = (int'(rd_ptr_q) == MAX_OUT - 1) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    gnt_o          = '0;
    rvalid_o       = '0;
    err_o          = '0;
    gnt_o[win]     = grant;
    rvalid_o[head] = pop;
    err_o[head]    = pop & host_err_i;
  end

  // The winner is frozen once the host stalls, so fields stay stable until grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_FREE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      unexp_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          if (host_req_o && !host_gnt_i) begin
            state_q <= ST_LOCKED;
            sel_q   <= free_win;
          end
        end
        ST_LOCKED: begin
          if (grant) begin
            state_q <= ST_FREE;
          end
        end
        default: state_q <= ST_FREE;
      endcase

      if (grant) begin
        ptr_q    <= ptr_next;
        wr_ptr_q <= wr_next;
      end
      if (pop) begin
        rd_ptr_q <= rd_next;
      end

      if (grant && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!grant && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (host_rvalid_i && (cnt_q == '0)) begin
        unexp_q <= 1'b1;
      end
    end
  end

  // Owner storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (grant) begin
      fifo_q[wr_ptr_q] <= win;
    end
  end

endmodule

// File: doc/ibex_host_arb.md
# ibex_host_arb

Shares the single Ibex host port of the systolic-array wrapper between N Ibex-protocol requesters: the three MM2S read bridges and the S2MM write bridge. It does round-robin request arbitration and locks the selection until grant. Each granted transaction's owner is recorded in an in-order outstanding FIFO so that `rvalid`/`err`/`rdata` return only to that owner. It sits between the per-DMA `saxi_to_host` bridges and the `host_*` ports of the wrapper.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, at least 2. Index 0 is mm2s_0 … index 3 is s2mm.
- `MAX_OUT`, 4: maximum outstanding granted transactions. Must be a power of 2 and at least 1.
- `AW`, 32: address width.
- `DW`, 32: data width. Byte-enable width is DW/8.

Ports (vectors are packed with requester i in slice i):
- `clk` input 1: single clock; all state on rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `req_i` input N_REQ: per-requester request.
- `addr_i` input N_REQ*AW: per-requester address.
- `we_i` input N_REQ: per-requester write enable.
- `be_i` input N_REQ*DW/8: per-requester byte enables.
- `wdata_i` input N_REQ*DW: per-requester write data.
- `gnt_o` output N_REQ: per-requester grant.
- `rvalid_o` output N_REQ: per-requester response valid.
- `err_o` output N_REQ: per-requester error, qualified by rvalid_o.
- `rdata_o` output DW: read data broadcast to all requesters.
- `host_req_o` output 1: host request.
- `host_addr_o` output AW: host address.
- `host_we_o` output 1: host write enable.
- `host_be_o` output DW/8: host byte enables.
- `host_wdata_o` output DW: host write data.
- `host_gnt_i` input 1: host grant.
- `host_rvalid_i` input 1: host response valid.
- `host_err_i` input 1: host error.
- `host_rdata_i` input DW: host read data.
- `unexp_rsp_o` output 1: sticky flag, set by a `host_rvalid_i` that arrives with no outstanding transaction.

## Operation
- Arbiter states:
  - FREE: the winner is the first requester with `req_i` high, searching from `ptr` upward with wrap.
  - LOCKED: the winner is held in `sel_q`.
- FREE→LOCKED when `host_req_o` is high and `host_gnt_i` is low; the combinational winner is captured into `sel_q`.
- LOCKED→FREE on `host_gnt_i`. Requests stay stable until grant, which the Ibex protocol guarantees.
- In LOCKED, a requester that drops `req_i` before grant is a protocol violation. The arbiter keeps driving that requester's fields regardless.
- `host_req_o` = (FREE ? |req_i : 1) & (cnt < MAX_OUT).
- Host address/we/be/wdata are muxed from the current winner. When no request is pending they are the winner-0 fields, treated as don't-care.
- `gnt_o[w]` = `host_gnt_i` & `host_req_o` for the winner w; all other bits are 0.
- On a grant:
  - `ptr` ← (w+1) mod N_REQ.
  - w is pushed into the outstanding FIFO (MAX_OUT entries, id width clog2(N_REQ)) and `cnt` increments.
- On `host_rvalid_i` with `cnt` > 0:
  - The FIFO head h is popped and `cnt` decrements.
  - `rvalid_o[h]` = 1 and `err_o[h]` = `host_err_i`.
- Push and pop in the same cycle: `cnt` is unchanged, and the popped entry is the old head.
- Full (`cnt` == MAX_OUT): `host_req_o` is forced low and no grant is passed through. A pop in the same cycle does not unblock the request until the next cycle.
- Empty with `host_rvalid_i` high: the response is dropped, every `rvalid_o` bit is 0, and `unexp_rsp_o` is set. It stays set until reset.
- `rdata_o` = `host_rdata_i` at all times.

## Timing
- Request→`host_req_o`, `host_gnt_i`→`gnt_o`, and `host_rvalid_i`→`rvalid_o` are all combinational, with zero added latency.
- A response may not arrive in the grant cycle; the earliest is 1 cycle later, per the Ibex protocol.
- Reset values:
  - State: FREE; `ptr` = 0; `cnt` = 0; FIFO pointers = 0; `unexp_rsp_o` = 0.
  - Outputs follow from that state. `gnt_o`, `rvalid_o` and `err_o` are 0 whenever their inputs are 0.
- Reset mid-transaction: all outstanding ownership is discarded immediately and asynchronously. Late host responses after reset set `unexp_rsp_o`.
- Fairness: with all N_REQ requesting continuously and `host_gnt_i` = 1 every cycle, grants rotate 0,1,2,3,0,… with one grant per cycle. This holds while `cnt` < MAX_OUT.

## Test plan
- **Single read:** req_i = 4'b0010, addr_i[1] = 0x100, gnt after 2 cycles, rvalid 1 cycle later with rdata 0xDEADBEEF → `host_addr_o` = 0x100 held stable through LOCKED; `gnt_o` = 4'b0010 once; `rvalid_o` = 4'b0010 with rdata 0xDEADBEEF.
- **Round-robin:** req_i = 4'b1111 for 8 cycles, `host_gnt_i` = 1, rvalid 1 cycle after each grant → grant order 0,1,2,3,0,1,2,3; each `rvalid_o` bit goes to the matching owner in order.
- **Lock:** req_i = 4'b0100, `host_gnt_i` held low 3 cycles, then req_i[0] rises → the host still presents requester 2 until grant; requester 0 is granted next.
- **Full stall:** MAX_OUT = 4; 4 grants with no rvalid → `host_req_o` = 0 while requests are pending. One rvalid → `host_req_o` = 1 on the next cycle.
- **Simultaneous push/pop:** grant to requester 3 in the same cycle as rvalid for head requester 1 → `rvalid_o` = 4'b0010; `cnt` unchanged; the next rvalid goes to requester 3. `host_err_i` = 1 on that next response gives `err_o[3]` = 1.
- **Unexpected response and reset:** rvalid with `cnt` = 0 → `rvalid_o` = 0 and `unexp_rsp_o` = 1, sticky. Then assert `rstn` low with 2 outstanding → `cnt` = 0 and `unexp_rsp_o` = 0 immediately.
